uart_frame_loader: RTL and testbench

- Controller that sequences received UART bytes into a dual-bank (ping-pong) frame buffer in the true-dual-port BRAM.
- Sits between the `uart_basic` receive outputs (`rx_data`, `rx_ready`) and BRAM port A. Hunts for a sync byte, writes a fixed-length payload into the current write bank, then checks a trailing checksum byte.
- A passing frame is handed to the downstream consumer, which reads it through BRAM port B. Reception continues into the other bank while the consumer works.

---
 rtl/uart_frame_loader_if.sv | 32 +++
 rtl/uart_frame_loader.sv | 175 +++++++++++++++++
 tb/tb_uart_frame_loader.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_loader_if.sv
// Bundle of the receive strobe, BRAM port A write bus and consumer
// handshake signals shared by the frame loader and its surroundings.
interface uart_frame_loader_if #(
    parameter int ADDR_W = 6
);
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W:0]   mem_addr;
    logic [7:0]        mem_din;
    logic              frame_valid;
    logic              rd_bank;
    logic              frame_ack;
    logic              frame_err;
    logic              frame_drop;
    logic [7:0]        err_count;
    logic              busy;

    // Frame loader side: consumes received bytes and acks, drives the rest.
    modport slave (
        input  rx_data, rx_ready, frame_ack,
        output mem_we, mem_addr, mem_din, frame_valid, rd_bank,
               frame_err, frame_drop, err_count, busy
    );

    // Environment side: UART receiver, BRAM and downstream consumer.
    modport master (
        output rx_data, rx_ready, frame_ack,
        input  mem_we, mem_addr, mem_din, frame_valid, rd_bank,
               frame_err, frame_drop, err_count, busy
    );
endinterface

// File: rtl/uart_frame_loader.sv
// Sequences received UART bytes into a ping-pong frame buffer.
// Hunts for a sync byte, writes FRAME_LEN payload bytes into the current
// write bank, validates the trailing additive checksum and hands good
// frames to the consumer, which releases each bank with frame_ack.
module uart_frame_loader #(
    parameter int          FRAME_LEN      = 64,
    parameter int          ADDR_W         = 6,
    parameter logic [7:0]  SYNC_BYTE      = 8'h01,
    parameter int          TIMEOUT_CYCLES = 100_000
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_frame_loader_if.slave   bus
);

    localparam int CNT_W   = ADDR_W + 1;
    localparam int TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [CNT_W-1:0]   LAST_PAYLOAD = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0]   LAST_DISCARD = CNT_W'(FRAME_LEN);
    localparam logic [TIMER_W-1:0] TIMER_LAST   = TIMER_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2,
        DISCARD = 2'd3
    } state_t;

    state_t             state_q,      state_d;
    logic               wr_bank_q,    wr_bank_d;
    logic               rd_bank_q,    rd_bank_d;
    logic [1:0]         bank_full_q,  bank_full_d;
    logic [CNT_W-1:0]   cnt_q,        cnt_d;
    logic [7:0]         sum_q,        sum_d;
    logic [TIMER_W-1:0] timer_q,      timer_d;
    logic               mem_we_q,     mem_we_d;
    logic [ADDR_W:0]    mem_addr_q,   mem_addr_d;
    logic [7:0]         mem_din_q,    mem_din_d;
    logic               err_q,        err_d;
    logic               drop_q,       drop_d;
    logic [7:0]         err_count_q,  err_count_d;

    // Next-state logic: frame sequencing, inter-byte timeout, bank bookkeeping.
    // cnt_q doubles as the payload offset and the discarded-byte counter,
    // which is why it carries one extra bit (discard runs to FRAME_LEN).
    always_comb begin
        state_d     = state_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        bank_full_d = bank_full_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        timer_d     = timer_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        err_d       = 1'b0;
        drop_d      = 1'b0;
        err_count_d = err_count_q;

        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (bus.rx_ready && bus.rx_data == SYNC_BYTE) begin
                    cnt_d = '0;
                    if (!bank_full_q[wr_bank_q]) begin
                        state_d = PAYLOAD;
                        sum_d   = 8'h00;
                    end else begin
                        drop_d  = 1'b1;
                        state_d = DISCARD;
                    end
                end
            end
            PAYLOAD: begin
                if (bus.rx_ready) begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = {wr_bank_q, cnt_q[ADDR_W-1:0]};
                    mem_din_d  = bus.rx_data;
                    sum_d      = sum_q + bus.rx_data;
                    cnt_d      = cnt_q + 1'b1;
                    if (cnt_q == LAST_PAYLOAD) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                if (bus.rx_ready) begin
                    if (bus.rx_data == sum_q) begin
                        bank_full_d[wr_bank_q] = 1'b1;
                        wr_bank_d              = ~wr_bank_q;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            DISCARD: begin
                if (bus.rx_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_DISCARD) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE) begin
            if (bus.rx_ready) begin
                timer_d = '0;
            end else if (timer_q == TIMER_LAST) begin
                state_d = IDLE;
                err_d   = 1'b1;
                timer_d = '0;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end

        if (bus.frame_ack && bank_full_q[rd_bank_q]) begin
            bank_full_d[rd_bank_q] = 1'b0;
            rd_bank_d              = ~rd_bank_q;
        end

        if (err_d && err_count_q != 8'hFF) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    // State and output registers with synchronous reset from any state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            bank_full_q <= 2'b00;
            cnt_q       <= '0;
            sum_q       <= 8'h00;
            timer_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= 8'h00;
            err_q       <= 1'b0;
            drop_q      <= 1'b0;
            err_count_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            bank_full_q <= bank_full_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            timer_q     <= timer_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            err_q       <= err_d;
            drop_q      <= drop_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_din     = mem_din_q;
    assign bus.frame_valid = bank_full_q[rd_bank_q];
    assign bus.rd_bank     = rd_bank_q;
    assign bus.frame_err   = err_q;
    assign bus.frame_drop  = drop_q;
    assign bus.err_count   = err_count_q;
    assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_frame_loader.sv
// Self-checking bench for uart_frame_loader: a frame-level model tracks
// committed/consumed frame counts and predicts every output each cycle;
// directed scenarios add hand-computed literal expectations.
module tb_uart_frame_loader;

    localparam int         FL   = 64;
    localparam int         AW   = 6;
    localparam int         TO   = 300;
    localparam logic [7:0] SYNC = 8'h01;

    logic clk;
    logic reset;

    uart_frame_loader_if #(.ADDR_W(AW)) bus ();

    uart_frame_loader #(
        .FRAME_LEN      (FL),
        .ADDR_W         (AW),
        .SYNC_BYTE      (SYNC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmpEn  = 1'b0;

    // Frame-level model state: 0 hunt, 1 collect, 2 await checksum, 3 discard.
    int         mMode    = 0;
    int         mGot     = 0;
    int         mDisc    = 0;
    int         mIdle    = 0;
    int         nCommit  = 0;
    int         nConsume = 0;
    int         mErrCnt  = 0;
    logic [7:0] mPay[$];
    int         expWe    = 0;
    int         expAddr  = 0;
    int         expDin   = 0;
    int         expErr   = 0;
    int         expDrop  = 0;

    // Observed-event counters used by the literal checks.
    int weCount   = 0;
    int firstAddr = -1;
    int lastAddr  = -1;
    int dropCount = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at time %0t", name, actual, expected, $time);
        end
    endtask

    // Inter-byte silence inside a frame ends the frame after TO idle clocks.
    task automatic modelIdle();
        if (mIdle == TO - 1) begin
            mMode  = 0;
            expErr = 1;
            mIdle  = 0;
        end else begin
            mIdle++;
        end
    endtask

    // Advance the model by one clock edge with the given inputs.
    task automatic modelStep(input logic rdy, input logic [7:0] d, input logic ack, input logic rst);
        int occ;
        int s;
        expWe   = 0;
        expErr  = 0;
        expDrop = 0;
        if (rst) begin
            mMode = 0; mGot = 0; mDisc = 0; mIdle = 0;
            nCommit = 0; nConsume = 0; mErrCnt = 0;
            mPay.delete();
            return;
        end
        occ = nCommit - nConsume;
        case (mMode)
            0: begin
                if (rdy && d == SYNC) begin
                    mIdle = 0;
                    if (occ < 2) begin
                        mMode = 1;
                        mGot  = 0;
                        mPay.delete();
                    end else begin
                        expDrop = 1;
                        mMode   = 3;
                        mDisc   = 0;
                    end
                end
            end
            1: begin
                if (rdy) begin
                    expWe   = 1;
                    expAddr = (nCommit % 2) * FL + mGot;
                    expDin  = int'(d);
                    mPay.push_back(d);
                    mGot++;
                    mIdle = 0;
                    if (mGot == FL) mMode = 2;
                end else begin
                    modelIdle();
                end
            end
            2: begin
                if (rdy) begin
                    s = 0;
                    foreach (mPay[i]) s += int'(mPay[i]);
                    if (int'(d) == s % 256) nCommit++;
                    else expErr = 1;
                    mMode = 0;
                    mIdle = 0;
                end else begin
                    modelIdle();
                end
            end
            default: begin
                if (rdy) begin
                    mDisc++;
                    mIdle = 0;
                    if (mDisc == FL + 1) mMode = 0;
                end else begin
                    modelIdle();
                end
            end
        endcase
        if (ack && occ > 0) nConsume++;
        if (expErr != 0 && mErrCnt < 255) mErrCnt++;
    endtask

    // Compare every DUT output against the model once per cycle.
    always @(negedge clk) begin
        if (cmpEn) begin
            checkOutput("mem_we", bus.mem_we, expWe);
            if (expWe != 0) begin
                checkOutput("mem_addr", bus.mem_addr, expAddr);
                checkOutput("mem_din", bus.mem_din, expDin);
            end
            checkOutput("frame_err", bus.frame_err, expErr);
            checkOutput("frame_drop", bus.frame_drop, expDrop);
            checkOutput("err_count", bus.err_count, mErrCnt);
            checkOutput("busy", bus.busy, (mMode != 0));
            checkOutput("frame_valid", bus.frame_valid, (nCommit - nConsume > 0));
            checkOutput("rd_bank", bus.rd_bank, nConsume % 2);
        end
    end

    // Tally write pulses and drops for the scenario-level checks.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            if (weCount == 0) firstAddr = int'(bus.mem_addr);
            lastAddr = int'(bus.mem_addr);
            weCount++;
        end
        if (bus.frame_drop === 1'b1) dropCount++;
    end

    task automatic clearCounters();
        weCount   = 0;
        firstAddr = -1;
        lastAddr  = -1;
        dropCount = 0;
    endtask

    // One clock of stimulus; returns just after the falling edge settles.
    task automatic applyStimulus(input logic rdy, input logic [7:0] d, input logic ack, input logic rst);
        bus.rx_ready  = rdy;
        bus.rx_data   = d;
        bus.frame_ack = ack;
        reset         = rst;
        @(posedge clk);
        modelStep(rdy, d, ack, rst);
        @(negedge clk);
        #1;
        bus.rx_ready  = 1'b0;
        bus.frame_ack = 1'b0;
        reset         = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] d, input int gap);
        applyStimulus(1'b1, d, 1'b0, 1'b0);
        repeat (gap) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic sendFrame(input logic [7:0] first, input logic [7:0] chk, input int gap);
        sendByte(SYNC, gap);
        for (int i = 0; i < FL; i++) sendByte(8'(first + i), gap);
        sendByte(chk, gap);
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        clearCounters();
    endtask

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        reset         = 1'b1;
        bus.rx_ready  = 1'b0;
        bus.rx_data   = 8'h00;
        bus.frame_ack = 1'b0;

        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        cmpEn = 1'b1;
        doReset();
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_valid", bus.frame_valid, 0);
        checkOutput("reset_errcnt", bus.err_count, 0);

        $display("[TB] good frame");
        sendFrame(8'h00, 8'hE0, 1);
        checkOutput("t1_we_count", weCount, 64);
        checkOutput("t1_first_addr", firstAddr, 0);
        checkOutput("t1_last_addr", lastAddr, 63);
        checkOutput("t1_valid", bus.frame_valid, 1);
        checkOutput("t1_rd_bank", bus.rd_bank, 0);
        clearCounters();
        sendFrame(8'h01, 8'h20, 1);
        checkOutput("t1_second_bank_addr", firstAddr, 64);

        $display("[TB] bad checksum");
        doReset();
        sendFrame(8'h00, 8'hE1, 1);
        checkOutput("t2_errcnt", bus.err_count, 1);
        checkOutput("t2_valid", bus.frame_valid, 0);
        clearCounters();
        sendFrame(8'h00, 8'hE0, 1);
        checkOutput("t2_retry_addr", firstAddr, 0);
        checkOutput("t2_retry_valid", bus.frame_valid, 1);

        $display("[TB] ping-pong and overflow");
        doReset();
        sendFrame(8'h00, 8'hE0, 1);
        sendFrame(8'h01, 8'h20, 1);
        clearCounters();
        sendFrame(8'h00, 8'hE0, 1);
        checkOutput("t3_drop_count", dropCount, 1);
        checkOutput("t3_discard_writes", weCount, 0);
        checkOutput("t3_busy_after", bus.busy, 0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("t3_ack1_rd", bus.rd_bank, 1);
        checkOutput("t3_ack1_valid", bus.frame_valid, 1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("t3_ack2_valid", bus.frame_valid, 0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("t3_stray_ack_rd", bus.rd_bank, 0);

        $display("[TB] timeout");
        doReset();
        sendByte(SYNC, 1);
        for (int i = 0; i < 9; i++) sendByte(8'(8'h40 + i), 1);
        sendByte(8'h49, 0);
        n = 0;
        do begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
            n++;
        end while (bus.frame_err !== 1'b1 && n < 2 * TO);
        checkOutput("t4_timeout_cycles", n, TO);
        checkOutput("t4_busy", bus.busy, 0);
        clearCounters();
        sendByte(SYNC, 1);
        sendByte(8'h77, 1);
        checkOutput("t4_restart_addr", firstAddr, 0);

        $display("[TB] reset mid-frame");
        doReset();
        sendByte(SYNC, 1);
        for (int i = 0; i < 30; i++) sendByte(8'(i), 1);
        sendByte(8'd30, 0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("t5_we", bus.mem_we, 0);
        checkOutput("t5_busy", bus.busy, 0);
        checkOutput("t5_valid", bus.frame_valid, 0);
        clearCounters();
        sendFrame(8'h00, 8'hE0, 1);
        checkOutput("t5_addr", firstAddr, 0);
        checkOutput("t5_valid_after", bus.frame_valid, 1);
        checkOutput("t5_rd_bank", bus.rd_bank, 0);

        $display("[TB] commit and ack together");
        doReset();
        sendFrame(8'h00, 8'hE0, 1);
        sendByte(SYNC, 1);
        for (int i = 0; i < FL; i++) sendByte(8'(1 + i), 1);
        applyStimulus(1'b1, 8'h20, 1'b1, 1'b0);
        checkOutput("t6_valid", bus.frame_valid, 1);
        checkOutput("t6_rd_bank", bus.rd_bank, 1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("t6_drained", bus.frame_valid, 0);

        $display("[TB] err_count saturation");
        doReset();
        for (int k = 0; k < 256; k++) sendFrame(8'h00, 8'hE1, 0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("t7_errcnt_sat", bus.err_count, 255);

        cmpEn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
